fib_job_scheduler: RTL and testbench

//  Sequences the synthesized fib kernel ("main": r_enable/init_n/init_a/init_b in, w_enable/result out).

---
 rtl/fib_job_scheduler.sv | 171 +++++++++++++++++
 tb/tb_fib_job_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_job_scheduler.sv
// fib_job_scheduler: queues fib jobs in a small FIFO, launches them one at a
// time on the fib kernel, guards each run with a watchdog and returns the
// result plus tag over a valid/ready port.
module fib_job_scheduler #(
  parameter int unsigned W       = 32,
  parameter int unsigned TAGW    = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            job_valid,
  output logic            job_ready,
  input  logic [W-1:0]    job_n,
  input  logic [W-1:0]    job_a,
  input  logic [W-1:0]    job_b,
  input  logic [TAGW-1:0] job_tag,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [W-1:0]    res_data,
  output logic [TAGW-1:0] res_tag,
  output logic            res_timeout,
  output logic            kern_start,
  output logic [W-1:0]    kern_n,
  output logic [W-1:0]    kern_a,
  output logic [W-1:0]    kern_b,
  input  logic            kern_done,
  input  logic [W-1:0]    kern_result,
  output logic            busy,
  output logic [15:0]     jobs_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned EW = 3 * W + TAGW;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_count;
  logic [PW-1:0]   w_count_nxt;
  logic [CW-1:0]   r_wdog;
  logic            w_push;
  logic            w_pop;
  logic            w_run_done;
  logic            w_run_to;
  logic            w_resp_acc;
  logic            r_job_ready;
  logic            r_res_valid;
  logic [W-1:0]    r_res_data;
  logic [TAGW-1:0] r_tag;
  logic            r_res_timeout;
  logic            r_kern_start;
  logic [W-1:0]    r_kern_n;
  logic [W-1:0]    r_kern_a;
  logic [W-1:0]    r_kern_b;
  logic            r_busy;
  logic [15:0]     r_jobs_done;

  assign job_ready   = r_job_ready;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_tag     = r_tag;
  assign res_timeout = r_res_timeout;
  assign kern_start  = r_kern_start;
  assign kern_n      = r_kern_n;
  assign kern_a      = r_kern_a;
  assign kern_b      = r_kern_b;
  assign busy        = r_busy;
  assign jobs_done   = r_jobs_done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode plus FIFO/handshake qualifiers
  always_comb begin
    w_state_nxt = r_state;
    w_push      = job_valid && r_job_ready;
    w_pop       = 1'b0;
    w_run_done  = 1'b0;
    w_run_to    = 1'b0;
    w_resp_acc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: w_state_nxt = S_RUN;
      S_RUN: begin
        if (kern_done) begin
          w_run_done  = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_wdog == CW'(TIMEOUT - 1)) begin
          w_run_to    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          w_resp_acc  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + PW'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - PW'(1);
  end

  // Job storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {job_n, job_a, job_b, job_tag};
  end

  // FIFO pointers, kernel launch, watchdog, response and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_job_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_kern_start  <= 1'b0;
      r_kern_n      <= '0;
      r_kern_a      <= '0;
      r_kern_b      <= '0;
      r_tag         <= '0;
      r_wdog        <= '0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_timeout <= 1'b0;
      r_jobs_done   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        {r_kern_n, r_kern_a, r_kern_b, r_tag} <= r_mem[r_rd_ptr];
      end
      r_count      <= w_count_nxt;
      r_job_ready  <= (w_count_nxt != PW'(DEPTH));
      r_busy       <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      r_kern_start <= (w_state_nxt == S_LAUNCH);
      if (r_state == S_LAUNCH)                   r_wdog <= '0;
      else if (r_state == S_RUN && !w_run_to)    r_wdog <= r_wdog + CW'(1);
      if (w_run_done) begin
        r_res_data    <= kern_result;
        r_res_timeout <= 1'b0;
        r_res_valid   <= 1'b1;
      end else if (w_run_to) begin
        r_res_data    <= '0;
        r_res_timeout <= 1'b1;
        r_res_valid   <= 1'b1;
      end else if (w_resp_acc) begin
        r_res_valid   <= 1'b0;
        r_jobs_done   <= r_jobs_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fib_job_scheduler.sv
// Directed bench for fib_job_scheduler with a behavioural fib kernel stub.
module tb_fib_job_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready;
  logic [31:0] job_n, job_a, job_b;
  logic [3:0]  job_tag;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic        res_timeout, kern_start;
  logic [31:0] kern_n, kern_a, kern_b;
  logic        kern_done = 1'b0;
  logic [31:0] kern_result = 32'd0;
  logic        busy;
  logic [15:0] jobs_done;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic stub_hang = 1'b0;
  logic [31:0] k_n = 0, k_a = 0, k_b = 0;
  logic k_run = 1'b0;
  logic [31:0] q_data[$];
  logic [3:0]  q_tag[$];

  fib_job_scheduler #(.W(32), .TAGW(4), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_n(job_n), .job_a(job_a), .job_b(job_b), .job_tag(job_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_timeout(res_timeout), .kern_start(kern_start),
    .kern_n(kern_n), .kern_a(kern_a), .kern_b(kern_b), .kern_done(kern_done),
    .kern_result(kern_result), .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  // Fib kernel: fib(n,a,b) = n==0 ? a : fib(n-1, a+b, a); done is a level cleared on start
  always @(posedge clk) begin
    if (kern_start) begin
      k_n <= kern_n; k_a <= kern_a; k_b <= kern_b; k_run <= 1'b1; kern_done <= 1'b0;
    end else if (k_run && !stub_hang) begin
      if (k_n == 0) begin
        kern_done <= 1'b1; kern_result <= k_a; k_run <= 1'b0;
      end else begin
        k_n <= k_n - 1; k_a <= k_a + k_b; k_b <= k_a;
      end
    end
  end

  // Count launches and record every accepted result
  always @(posedge clk) begin
    if (kern_start) start_cnt <= start_cnt + 1;
    if (res_valid && res_ready) begin
      q_data.push_back(res_data);
      q_tag.push_back(res_tag);
    end
  end

  task automatic push_job(input logic [31:0] n, a, b, input logic [3:0] tag, output bit ok);
    ok = 1'b0;
    job_valid = 1'b1; job_n = n; job_a = a; job_b = b; job_tag = tag;
    for (int i = 0; i < 200; i++) begin
      if (job_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    job_valid = 1'b0;
  endtask

  task automatic wait_res(output int cyc);
    cyc = -1;
    for (int i = 0; i < 300; i++) begin
      if (res_valid) begin
        cyc = i;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_job_ready got %b exp 1", job_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (kern_start !== 1'b0) begin errors++; $display("FAIL reset_kern_start got %b exp 0", kern_start); end
    checks++; if (jobs_done !== 16'd0) begin errors++; $display("FAIL reset_jobs_done got %0d exp 0", jobs_done); end
    checks++; if ({res_data, res_tag, res_timeout} !== 37'd0) begin errors++; $display("FAIL reset_res got %h/%h/%b exp 0", res_data, res_tag, res_timeout); end
    checks++; if ({kern_n, kern_a, kern_b} !== 96'd0) begin errors++; $display("FAIL reset_kern_args got %h/%h/%h exp 0", kern_n, kern_a, kern_b); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok; int cyc; int s0;
    s0 = start_cnt;
    push_job(32'd5, 32'd1, 32'd0, 4'd3, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_push got %b exp 1", ok); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    wait_res(cyc);
    checks++; if (cyc != 9) begin errors++; $display("FAIL single_latency got %0d exp 9", cyc); end
    checks++; if (res_data !== 32'd8) begin errors++; $display("FAIL single_data got %0d exp 8", res_data); end
    checks++; if (res_tag !== 4'd3) begin errors++; $display("FAIL single_tag got %0d exp 3", res_tag); end
    checks++; if (res_timeout !== 1'b0) begin errors++; $display("FAIL single_timeout got %b exp 0", res_timeout); end
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL single_starts got %0d exp 1", start_cnt - s0); end
    checks++; if ({kern_n, kern_a, kern_b} !== {32'd5, 32'd1, 32'd0}) begin errors++; $display("FAIL single_kern_args got %0d/%0d/%0d exp 5/1/0", kern_n, kern_a, kern_b); end
    accept_res();
    checks++; if (jobs_done !== 16'd1) begin errors++; $display("FAIL single_jobs_done got %0d exp 1", jobs_done); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_res_drop got %b exp 0", res_valid); end
  endtask

  task automatic test_hold();
    bit ok; int cyc; int bad;
    push_job(32'd0, 32'd7, 32'd9, 4'd5, ok);
    wait_res(cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL hold_latency got %0d exp 4", cyc); end
    checks++; if (res_data !== 32'd7) begin errors++; $display("FAIL hold_data got %0d exp 7", res_data); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== 32'd7 || res_tag !== 4'd5) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d unstable cycles exp 0", bad); end
    accept_res();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL hold_drop got %b exp 0", res_valid); end
    checks++; if (jobs_done !== 16'd2) begin errors++; $display("FAIL hold_jobs_done got %0d exp 2", jobs_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc; bit acc; int bad;
    logic [31:0] exp_d [6];
    logic [3:0]  exp_t [6];
    exp_d = '{32'd2, 32'd3, 32'd5, 32'd4, 32'd5, 32'd13};
    exp_t = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    q_data.delete(); q_tag.delete();
    res_ready = 1'b0;
    push_job(32'd1, 32'd1, 32'd1, 4'd1, ok);
    wait_res(cyc);
    push_job(32'd2, 32'd1, 32'd1, 4'd2, ok);
    push_job(32'd3, 32'd1, 32'd1, 4'd3, ok);
    push_job(32'd0, 32'd4, 32'd0, 4'd4, ok);
    push_job(32'd4, 32'd1, 32'd0, 4'd5, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_fill got %b exp 1", ok); end
    checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b exp 0", job_ready); end
    job_valid = 1'b1; job_n = 32'd6; job_a = 32'd1; job_b = 32'd0; job_tag = 4'd6;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (job_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_full_hold got %0d ready cycles exp 0", bad); end
    res_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (job_ready) begin
        @(negedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    job_valid = 1'b0;
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_sixth_accept got %b exp 1", acc); end
    for (int i = 0; i < 300 && q_data.size() < 6; i++) @(negedge clk);
    res_ready = 1'b0;
    checks++; if (q_data.size() != 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", q_data.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < q_data.size()) begin
        checks++; if (q_tag[i] !== exp_t[i] || q_data[i] !== exp_d[i]) begin errors++; $display("FAIL b2b_result%0d got tag %0d data %0d exp tag %0d data %0d", i, q_tag[i], q_data[i], exp_t[i], exp_d[i]); end
      end
    end
    @(negedge clk);
    checks++; if (jobs_done !== 16'd8) begin errors++; $display("FAIL b2b_jobs_done got %0d exp 8", jobs_done); end
  endtask

  task automatic test_timeout();
    bit ok; int cyc; int cnt;
    stub_hang = 1'b1;
    push_job(32'd2, 32'd1, 32'd1, 4'd9, ok);
    for (int i = 0; i < 50; i++) begin
      if (kern_start) break;
      @(negedge clk);
    end
    cnt = 0;
    while (!res_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checks++; if (cnt != 17) begin errors++; $display("FAIL timeout_cycles got %0d exp 17", cnt); end
    checks++; if (res_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b exp 1", res_timeout); end
    checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL timeout_data got %0d exp 0", res_data); end
    checks++; if (res_tag !== 4'd9) begin errors++; $display("FAIL timeout_tag got %0d exp 9", res_tag); end
    accept_res();
    stub_hang = 1'b0;
    push_job(32'd3, 32'd2, 32'd1, 4'd10, ok);
    wait_res(cyc);
    checks++; if (res_data !== 32'd8 || res_timeout !== 1'b0 || res_tag !== 4'd10) begin errors++; $display("FAIL timeout_next got %0d/%b/%0d exp 8/0/10", res_data, res_timeout, res_tag); end
    accept_res();
    checks++; if (jobs_done !== 16'd10) begin errors++; $display("FAIL timeout_jobs_done got %0d exp 10", jobs_done); end
  endtask

  task automatic test_stale_done();
    bit ok; int cyc;
    push_job(32'd3, 32'd1, 32'd1, 4'd11, ok);
    wait_res(cyc);
    checks++; if (cyc != 7) begin errors++; $display("FAIL stale_latency got %0d exp 7", cyc); end
    checks++; if (res_data !== 32'd5) begin errors++; $display("FAIL stale_data got %0d exp 5", res_data); end
    accept_res();
    checks++; if (jobs_done !== 16'd11) begin errors++; $display("FAIL stale_jobs_done got %0d exp 11", jobs_done); end
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc; int s0;
    stub_hang = 1'b1;
    push_job(32'd1, 32'd1, 32'd1, 4'd12, ok);
    push_job(32'd1, 32'd1, 32'd1, 4'd13, ok);
    push_job(32'd1, 32'd1, 32'd1, 4'd14, ok);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_pre got busy %b valid %b exp 1/0", busy, res_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_res_valid got %b exp 0", res_valid); end
    checks++; if (jobs_done !== 16'd0) begin errors++; $display("FAIL rstmid_jobs_done got %0d exp 0", jobs_done); end
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL rstmid_job_ready got %b exp 1", job_ready); end
    s0 = start_cnt;
    repeat (20) @(negedge clk);
    checks++; if (start_cnt != s0 || res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_quiet got starts %0d valid %b busy %b exp 0/0/0", start_cnt - s0, res_valid, busy); end
    stub_hang = 1'b0;
    push_job(32'd1, 32'd3, 32'd4, 4'd7, ok);
    wait_res(cyc);
    checks++; if (res_data !== 32'd7 || res_tag !== 4'd7) begin errors++; $display("FAIL rstmid_after got %0d/%0d exp 7/7", res_data, res_tag); end
    accept_res();
    checks++; if (jobs_done !== 16'd1) begin errors++; $display("FAIL rstmid_after_count got %0d exp 1", jobs_done); end
  endtask

  initial begin
    rst = 1'b1; job_valid = 1'b0; res_ready = 1'b0;
    job_n = '0; job_a = '0; job_b = '0; job_tag = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_hold();
    test_back_to_back();
    test_timeout();
    test_stale_done();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit got expired exp finish");
    $fatal(1);
  end

endmodule
